// File: rtl/nv_ram_rwsp_4x64_fifo_ctrl.sv
// Valid/ready FIFO controller for an external 4x64 rwsp RAM; push-to-rd_pvld is 3 cycles, 1 push + 1 pop per cycle.
// wr_prdy drops when all 4 rows are held; s2 holds a 5th beat. Optional wr_count port under NV_RWSP_FIFO_COUNT_EN.
module nv_ram_rwsp_4x64_fifo_ctrl #(
  parameter int PD_W = 64,
  parameter int AW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_pvld,
  output logic            wr_prdy,
  input  logic [PD_W-1:0] wr_pd,
  output logic            rd_pvld,
  input  logic            rd_prdy,
  output logic [PD_W-1:0] rd_pd,
  output logic [AW-1:0]   ram_wa,
  output logic            ram_we,
  output logic [PD_W-1:0] ram_di,
  output logic [AW-1:0]   ram_ra,
  output logic            ram_re,
  output logic            ram_ore,
  input  logic [PD_W-1:0] ram_dout
`ifdef NV_RWSP_FIFO_COUNT_EN
  ,
  output logic [AW:0]     wr_count
`endif
);

  localparam int unsigned DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   rows_used;
  logic [AW:0]   unissued;
  logic          s1_vld;
  logic          s2_vld;
  logic          push;
  logic          pop;
  logic          adv1;

  assign wr_prdy = !rst && (rows_used < DEPTH_C);
  assign push    = wr_pvld && wr_prdy;
  assign adv1    = !rst && s1_vld && (!s2_vld || rd_prdy);
  assign ram_re  = !rst && (unissued != '0) && (!s1_vld || adv1);
  assign rd_pvld = !rst && s2_vld;
  assign pop     = rd_pvld && rd_prdy;

  assign ram_we  = push;
  assign ram_wa  = wr_ptr;
  assign ram_di  = wr_pd;
  assign ram_ra  = rd_ptr;
  assign ram_ore = adv1;
  assign rd_pd   = ram_dout;

  // A row stays counted in rows_used until ore has captured it, so a stalled s1 keeps its row safe.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rows_used <= '0;
      unissued  <= '0;
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (ram_re) rd_ptr <= rd_ptr + 1'b1;

      case ({push, adv1})
        2'b10:   rows_used <= rows_used + ONE_C;
        2'b01:   rows_used <= rows_used - ONE_C;
        default: rows_used <= rows_used;
      endcase

      case ({push, ram_re})
        2'b10:   unissued <= unissued + ONE_C;
        2'b01:   unissued <= unissued - ONE_C;
        default: unissued <= unissued;
      endcase

      if (ram_re)    s1_vld <= 1'b1;
      else if (adv1) s1_vld <= 1'b0;

      if (adv1)     s2_vld <= 1'b1;
      else if (pop) s2_vld <= 1'b0;
    end
  end

`ifdef NV_RWSP_FIFO_COUNT_EN
  assign wr_count = rows_used;
`else
`endif

endmodule

// File: tb/tb_nv_ram_rwsp_4x64_fifo_ctrl.sv
// Directed + random bench for nv_ram_rwsp_4x64_fifo_ctrl with a behavioural 4x64 rwsp RAM and a scoreboard.
module tb_nv_ram_rwsp_4x64_fifo_ctrl;
  localparam int PD_W = 64;
  localparam int AW   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_pvld;
  logic            wr_prdy;
  logic [PD_W-1:0] wr_pd;
  logic            rd_pvld;
  logic            rd_prdy;
  logic [PD_W-1:0] rd_pd;
  logic [AW-1:0]   ram_wa;
  logic            ram_we;
  logic [PD_W-1:0] ram_di;
  logic [AW-1:0]   ram_ra;
  logic            ram_re;
  logic            ram_ore;
  logic [PD_W-1:0] ram_dout;
`ifdef NV_RWSP_FIFO_COUNT_EN
  logic [AW:0]     wr_count;
`endif

  int checks   = 0;
  int failures = 0;
  int n_pop    = 0;
  int m_rows   = 0;
  int m_uniss  = 0;
  logic [PD_W-1:0] sb_q[$];

  always #5 clk = ~clk;

  nv_ram_rwsp_4x64_fifo_ctrl #(.PD_W(PD_W), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore),
    .ram_dout(ram_dout)
`ifdef NV_RWSP_FIFO_COUNT_EN
    , .wr_count(wr_count)
`endif
  );

  // Behavioural rwsp RAM: address register loaded by re, output register by ore.
  logic [PD_W-1:0] mem [4];
  logic [AW-1:0]   ra_q;
  logic [PD_W-1:0] dout_q;
  always @(posedge clk) begin
    if (ram_we)  mem[ram_wa] <= ram_di;
    if (ram_re)  ra_q <= ram_ra;
    if (ram_ore) dout_q <= mem[ra_q];
  end
  assign ram_dout = dout_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and occupancy model, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      m_rows  = 0;
      m_uniss = 0;
    end else begin
      if (ram_re) chk("re_with_unissued", 64'(m_uniss != 0), 64'd1);
      if (ram_we) chk("we_below_full", 64'(m_rows < 4), 64'd1);
      if (rd_pvld && rd_prdy) begin
        n_pop++;
        chk("sb_nonempty_on_pop", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) chk("sb_data", rd_pd, sb_q.pop_front());
      end
      if (wr_pvld && wr_prdy) sb_q.push_back(wr_pd);
      m_uniss = m_uniss + int'(wr_pvld && wr_prdy) - int'(ram_re);
      m_rows  = m_rows  + int'(wr_pvld && wr_prdy) - int'(ram_ore);
    end
  end

  initial begin
    int got;
    int sent;
    int cyc;
    int pop0;

    rst = 1'b1; wr_pvld = 1'b1; wr_pd = '1; rd_prdy = 1'b1;
    @(negedge clk);
    chk("rst_wr_prdy", 64'(wr_prdy), 64'd0);
    chk("rst_rd_pvld", 64'(rd_pvld), 64'd0);
    chk("rst_ram_we",  64'(ram_we),  64'd0);
    chk("rst_ram_re",  64'(ram_re),  64'd0);
    chk("rst_ram_ore", 64'(ram_ore), 64'd0);
`ifdef NV_RWSP_FIFO_COUNT_EN
    tick();
    @(negedge clk);
    chk("rst_wr_count", 64'(wr_count), 64'd0);
`endif
    tick();
    rst = 1'b0; wr_pvld = 1'b0;

    // 1: single beat latency
    wr_pvld = 1'b1; wr_pd = 64'hA5A5_0000_0000_0001;
    @(negedge clk);
    chk("t1_wr_prdy", 64'(wr_prdy), 64'd1);
    chk("t1_ram_we",  64'(ram_we),  64'd1);
    chk("t1_ram_wa",  64'(ram_wa),  64'd0);
    chk("t1_re_c0",   64'(ram_re),  64'd0);
    tick();
    wr_pvld = 1'b0;
    @(negedge clk);
    chk("t1_re_c1",  64'(ram_re),  64'd1);
    chk("t1_ra_c1",  64'(ram_ra),  64'd0);
    chk("t1_ore_c1", 64'(ram_ore), 64'd0);
    tick();
    @(negedge clk);
    chk("t1_ore_c2", 64'(ram_ore), 64'd1);
    chk("t1_re_c2",  64'(ram_re),  64'd0);
    chk("t1_vld_c2", 64'(rd_pvld), 64'd0);
    tick();
    @(negedge clk);
    chk("t1_vld_c3", 64'(rd_pvld), 64'd1);
    chk("t1_pd_c3",  rd_pd, 64'hA5A5_0000_0000_0001);
    tick();
    @(negedge clk);
    chk("t1_vld_c4", 64'(rd_pvld), 64'd0);
    tick();

    // 2: fill with consumer stalled, then drain
    rd_prdy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wr_pvld = 1'b1; wr_pd = 64'(k + 1);
      @(negedge clk);
      chk("t2_fill_prdy", 64'(wr_prdy), 64'(k < 5));
      tick();
    end
    wr_pvld = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t2_hold_prdy", 64'(wr_prdy), 64'd0);
      chk("t2_hold_pd",   rd_pd, 64'd1);
      tick();
    end
    rd_prdy = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_pvld) begin
        chk("t2_drain_pd", rd_pd, 64'(got + 1));
        got++;
      end
      tick();
    end
    chk("t2_drain_cnt", 64'(got), 64'd5);
    chk("t2_empty_vld", 64'(rd_pvld), 64'd0);

    // 3: full-rate stream
    sent = 0;
    pop0 = n_pop;
    for (int c = 0; c < 110; c++) begin
      wr_pvld = (sent < 100);
      wr_pd   = 64'h1000 + 64'(sent);
      @(negedge clk);
      if (wr_pvld) chk("t3_prdy", 64'(wr_prdy), 64'd1);
      if (c >= 3 && c < 103) chk("t3_vld", 64'(rd_pvld), 64'd1);
      if (c >= 103) chk("t3_tail_vld", 64'(rd_pvld), 64'd0);
      if (wr_pvld && wr_prdy) sent++;
      tick();
    end
    chk("t3_pop_cnt", 64'(n_pop - pop0), 64'd100);

    // 4: random traffic
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      wr_pvld = 1'($urandom_range(0, 1));
      rd_prdy = 1'($urandom_range(0, 1));
      wr_pd   = {$urandom, $urandom};
      @(negedge clk);
      if (wr_pvld && wr_prdy) sent++;
      tick();
      cyc++;
    end
    chk("t4_sent", 64'(sent), 64'd10000);
    wr_pvld = 1'b0; rd_prdy = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    chk("t4_sb_left", 64'(sb_q.size()), 64'd0);
    chk("t4_vld_idle", 64'(rd_pvld), 64'd0);
    tick();

    // 5: reset while full
    rd_prdy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wr_pvld = 1'b1; wr_pd = 64'h200 + 64'(k);
      tick();
    end
    wr_pvld = 1'b0;
    @(negedge clk);
    chk("t5_full_prdy", 64'(wr_prdy), 64'd0);
    chk("t5_full_vld",  64'(rd_pvld), 64'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_vld", 64'(rd_pvld), 64'd0);
    tick();
    rst = 1'b0; wr_pvld = 1'b1; wr_pd = 64'h7; rd_prdy = 1'b1;
    @(negedge clk);
    chk("t5_post_prdy", 64'(wr_prdy), 64'd1);
    chk("t5_post_vld0", 64'(rd_pvld), 64'd0);
    tick();
    wr_pvld = 1'b0;
    @(negedge clk);
    chk("t5_post_vld1", 64'(rd_pvld), 64'd0);
    tick();
    @(negedge clk);
    chk("t5_post_vld2", 64'(rd_pvld), 64'd0);
    tick();
    @(negedge clk);
    chk("t5_post_vld3", 64'(rd_pvld), 64'd1);
    chk("t5_post_pd",   rd_pd, 64'h7);
    tick();

`ifdef NV_RWSP_FIFO_COUNT_EN
    // 6: occupancy counter
    rd_prdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wr_pvld = 1'b1; wr_pd = 64'h300 + 64'(k);
      tick();
    end
    wr_pvld = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_count_2", 64'(wr_count), 64'd2);
    tick();
    wr_pvld = 1'b1; wr_pd = 64'h303; rd_prdy = 1'b1;
    @(negedge clk);
    chk("t6_both_ore", 64'(ram_ore), 64'd1);
    chk("t6_both_we",  64'(ram_we),  64'd1);
    tick();
    wr_pvld = 1'b0; rd_prdy = 1'b0;
    @(negedge clk);
    chk("t6_count_same", 64'(wr_count), 64'd2);
    tick();
    rd_prdy = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    chk("t6_count_0", 64'(wr_count), 64'd0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
